// File: rtl/usb_spi_arbiter_if.sv
// Bundle of requester handshakes, completion response and SPI pins for usb_spi_arbiter.
// The arbiter takes the slave side; requesters and the chip model take the master side.
interface usb_spi_arbiter_if;
  logic       req0_valid;
  logic       req0_write;
  logic [4:0] req0_reg;
  logic [7:0] req0_wdata;
  logic       req0_ready;
  logic       req1_valid;
  logic       req1_write;
  logic [4:0] req1_reg;
  logic [7:0] req1_wdata;
  logic       req1_ready;
  logic       rsp_valid;
  logic       rsp_id;
  logic [7:0] rsp_rdata;
  logic [7:0] rsp_status;
  logic       busy;
  logic       spi0_SCLK;
  logic       spi0_MOSI;
  logic       spi0_MISO;
  logic       spi0_SS_n;

  modport slave (
    input  req0_valid, req0_write, req0_reg, req0_wdata,
    input  req1_valid, req1_write, req1_reg, req1_wdata,
    input  spi0_MISO,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_rdata, rsp_status, busy,
    output spi0_SCLK, spi0_MOSI, spi0_SS_n
  );

  modport master (
    output req0_valid, req0_write, req0_reg, req0_wdata,
    output req1_valid, req1_write, req1_reg, req1_wdata,
    output spi0_MISO,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_rdata, rsp_status, busy,
    input  spi0_SCLK, spi0_MOSI, spi0_SS_n
  );
endinterface

// File: rtl/usb_spi_arbiter.sv
// Round-robin arbiter between two MAX3421E register requesters, each grant serialised
// into one 2-byte SPI mode-0 transaction (command byte, data byte).
//
//   state | meaning
//   IDLE  | arbitrate; accept a request and latch its payload
//   SETUP | SS_n low, first MOSI bit presented, SCLK low for CLK_DIV cycles
//   SHIFT | 16 SCLK high phases and the low phases between them
//   HOLD  | low phase after the last SCLK fall, SS_n still low
//   GAP   | SS_n high, response pulsed on entry, then back to IDLE
module usb_spi_arbiter #(
  parameter int CLK_DIV = 2
) (
  input logic              clk_clk,
  input logic              reset_reset_n,
  usb_spi_arbiter_if.slave bus
);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_div_check
    $error("usb_spi_arbiter: CLK_DIV must be in 1..255");
  end

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] tx_sr;
  logic [15:0] rx_sr;
  logic        sclk, mosi, ss_n, busy;
  logic        owner, last_grant;
  logic        rsp_valid, rsp_id;
  logic [7:0]  rsp_rdata, rsp_status;
  logic        tc, accept, grant_vld, grant_id;
  logic [15:0] word;

  assign tc = (cnt == 8'd0);

  always_comb begin
    grant_vld = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid)
      grant_id = ~last_grant;
    else
      grant_id = bus.req1_valid;
  end

  always_comb begin
    word = 16'h0000;
    if (grant_id)
      word = {bus.req1_reg, 1'b0, bus.req1_write, 1'b0,
              bus.req1_write ? bus.req1_wdata : 8'h00};
    else
      word = {bus.req0_reg, 1'b0, bus.req0_write, 1'b0,
              bus.req0_write ? bus.req0_wdata : 8'h00};
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld && reset_reset_n) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP:   if (tc) state_nxt = SHIFT;
      SHIFT:   if (tc && sclk && bit_cnt == 4'd15) state_nxt = HOLD;
      HOLD:    if (tc) state_nxt = GAP;
      GAP:     if (tc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req0_ready = accept & ~grant_id;
  assign bus.req1_ready = accept & grant_id;

  // SCLK is registered, so a phase ends on the terminal count and the next phase
  // starts on the same edge; MISO is sampled on the edge that raises SCLK.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      cnt        <= 8'd0;
      bit_cnt    <= 4'd0;
      tx_sr      <= 16'h0000;
      rx_sr      <= 16'h0000;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      ss_n       <= 1'b1;
      busy       <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_rdata  <= 8'h00;
      rsp_status <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      if (!tc)
        cnt <= cnt - 8'd1;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt        <= DIV_LOAD;
            bit_cnt    <= 4'd0;
            tx_sr      <= word;
            rx_sr      <= 16'h0000;
            mosi       <= word[15];
            ss_n       <= 1'b0;
            busy       <= 1'b1;
            owner      <= grant_id;
            last_grant <= grant_id;
          end
        end
        SETUP: begin
          if (tc) begin
            cnt   <= DIV_LOAD;
            sclk  <= 1'b1;
            rx_sr <= {rx_sr[14:0], bus.spi0_MISO};
          end
        end
        SHIFT: begin
          if (tc) begin
            cnt <= DIV_LOAD;
            if (sclk) begin
              sclk <= 1'b0;
              if (bit_cnt == 4'd15) begin
                mosi <= 1'b0;
              end else begin
                mosi    <= tx_sr[14];
                tx_sr   <= {tx_sr[14:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end else begin
              sclk  <= 1'b1;
              rx_sr <= {rx_sr[14:0], bus.spi0_MISO};
            end
          end
        end
        HOLD: begin
          if (tc) begin
            cnt        <= DIV_LOAD;
            ss_n       <= 1'b1;
            rsp_valid  <= 1'b1;
            rsp_id     <= owner;
            rsp_status <= rx_sr[15:8];
            rsp_rdata  <= rx_sr[7:0];
          end
        end
        GAP: begin
          if (tc)
            busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.spi0_SCLK  = sclk;
  assign bus.spi0_MOSI  = mosi;
  assign bus.spi0_SS_n  = ss_n;
  assign bus.busy       = busy;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_id     = rsp_id;
  assign bus.rsp_rdata  = rsp_rdata;
  assign bus.rsp_status = rsp_status;

endmodule

// File: tb/tb_usb_spi_arbiter.sv
// Directed bench for usb_spi_arbiter: one instance at CLK_DIV=2, one at CLK_DIV=1,
// a shared SPI slave model and monitor watching whichever instance is selected.
module tb_usb_spi_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  usb_spi_arbiter_if i0 ();
  usb_spi_arbiter_if i1 ();

  usb_spi_arbiter #(.CLK_DIV(2)) dut0 (.clk_clk(clk), .reset_reset_n(rst_n), .bus(i0));
  usb_spi_arbiter #(.CLK_DIV(1)) dut1 (.clk_clk(clk), .reset_reset_n(rst_n), .bus(i1));

  logic       sel = 1'b0;
  logic       r0_valid = 1'b0, r0_write = 1'b0, r1_valid = 1'b0, r1_write = 1'b0;
  logic [4:0] r0_reg = 5'd0, r1_reg = 5'd0;
  logic [7:0] r0_wdata = 8'h00, r1_wdata = 8'h00;
  logic       miso = 1'b0;
  logic [15:0] miso_word = 16'h0000;

  always_comb begin
    i0.req0_valid = ~sel & r0_valid;  i1.req0_valid = sel & r0_valid;
    i0.req1_valid = ~sel & r1_valid;  i1.req1_valid = sel & r1_valid;
    i0.req0_write = r0_write;  i1.req0_write = r0_write;
    i0.req1_write = r1_write;  i1.req1_write = r1_write;
    i0.req0_reg   = r0_reg;    i1.req0_reg   = r0_reg;
    i0.req1_reg   = r1_reg;    i1.req1_reg   = r1_reg;
    i0.req0_wdata = r0_wdata;  i1.req0_wdata = r0_wdata;
    i0.req1_wdata = r1_wdata;  i1.req1_wdata = r1_wdata;
    i0.spi0_MISO  = miso;      i1.spi0_MISO  = miso;
  end

  logic m_sclk, m_mosi, m_ss_n, m_ready0, m_ready1, m_rsp_valid, m_rsp_id, m_busy;
  logic [7:0] m_rdata, m_status;
  always_comb begin
    m_sclk      = sel ? i1.spi0_SCLK  : i0.spi0_SCLK;
    m_mosi      = sel ? i1.spi0_MOSI  : i0.spi0_MOSI;
    m_ss_n      = sel ? i1.spi0_SS_n  : i0.spi0_SS_n;
    m_ready0    = sel ? i1.req0_ready : i0.req0_ready;
    m_ready1    = sel ? i1.req1_ready : i0.req1_ready;
    m_rsp_valid = sel ? i1.rsp_valid  : i0.rsp_valid;
    m_rsp_id    = sel ? i1.rsp_id     : i0.rsp_id;
    m_rdata     = sel ? i1.rsp_rdata  : i0.rsp_rdata;
    m_status    = sel ? i1.rsp_status : i0.rsp_status;
    m_busy      = sel ? i1.busy       : i0.busy;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int acc_cyc[$], acc_id[$], rsp_cyc[$], rsp_id_q[$];
  logic [7:0] rsp_rd_q[$], rsp_st_q[$];
  logic [15:0] mosi_sr = 16'h0000;
  int pulses = 0, hi_run = 0, lo_run = 0, hi_min = 255, hi_max = 0, lo_min = 255, lo_max = 0;
  int ss_hi_run = 0, gap_min = 255, gap_max = 0, sclk_viol = 0, miso_idx = 0;
  bit seen_txn = 1'b0;
  logic p_sclk = 1'b0, p_ss_n = 1'b1;

  // Monitor plus MAX3421E MISO model: next bit presented after SS_n falls and after each SCLK fall.
  always @(negedge clk) begin
    if (m_ready0) begin acc_cyc.push_back(cyc); acc_id.push_back(0); end
    if (m_ready1) begin acc_cyc.push_back(cyc); acc_id.push_back(1); end
    if (m_rsp_valid) begin
      rsp_cyc.push_back(cyc); rsp_id_q.push_back(int'(m_rsp_id));
      rsp_rd_q.push_back(m_rdata); rsp_st_q.push_back(m_status);
    end
    if (m_sclk && m_ss_n) sclk_viol++;
    if (!m_ss_n && p_ss_n) begin
      miso_idx = 15; miso = miso_word[15];
      if (seen_txn) begin
        if (ss_hi_run < gap_min) gap_min = ss_hi_run;
        if (ss_hi_run > gap_max) gap_max = ss_hi_run;
      end
      seen_txn = 1'b1;
    end
    if (m_ss_n) ss_hi_run++; else ss_hi_run = 0;
    if (!m_ss_n) begin
      if (m_sclk && !p_sclk) begin
        pulses++;
        mosi_sr = {mosi_sr[14:0], m_mosi};
        if (pulses > 1) begin
          if (lo_run < lo_min) lo_min = lo_run;
          if (lo_run > lo_max) lo_max = lo_run;
        end
        hi_run = 1;
      end else if (m_sclk) begin
        hi_run++;
      end else if (p_sclk) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        lo_run = 1;
        if (miso_idx > 0) begin miso_idx--; miso = miso_word[miso_idx]; end
      end else begin
        lo_run++;
      end
    end
    p_sclk = m_sclk; p_ss_n = m_ss_n;
  end

  int n_assert = 0, n_fail = 0;
  int d_exp = 2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    acc_cyc.delete(); acc_id.delete(); rsp_cyc.delete(); rsp_id_q.delete();
    rsp_rd_q.delete(); rsp_st_q.delete();
    mosi_sr = 16'h0000; pulses = 0;
    hi_min = 255; hi_max = 0; lo_min = 255; lo_max = 0;
    gap_min = 255; gap_max = 0; sclk_viol = 0; seen_txn = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget);
    for (int i = 0; i < budget && acc_cyc.size() < n; i++) begin @(negedge clk); #1; end
    check("accept_count", 32'(acc_cyc.size()), 32'(n));
  endtask

  task automatic wait_rsp(input int n, input int budget);
    for (int i = 0; i < budget && rsp_cyc.size() < n; i++) begin @(negedge clk); #1; end
    check("rsp_count", 32'(rsp_cyc.size()), 32'(n));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && m_busy; i++) begin @(negedge clk); #1; end
    check("busy_low_after_txn", 32'(m_busy), 32'd0);
  endtask

  task automatic single(input bit id, input bit wr, input logic [4:0] rg,
                        input logic [7:0] wd, input logic [15:0] mw);
    @(posedge clk); #1;
    clear_mon(); miso_word = mw;
    if (id == 1'b0) begin r0_valid = 1'b1; r0_write = wr; r0_reg = rg; r0_wdata = wd; end
    else            begin r1_valid = 1'b1; r1_write = wr; r1_reg = rg; r1_wdata = wd; end
    wait_acc(1, 50);
    @(posedge clk); #1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    wait_rsp(1, 300);
    wait_idle();
  endtask

  task automatic check_txn(input string p, input int id, input logic [15:0] mosi_exp,
                           input logic [7:0] st_exp, input logic [7:0] rd_exp);
    check({p, "_rsp_pulses"}, 32'(rsp_cyc.size()), 32'd1);
    check({p, "_accept_id"}, 32'(acc_id[0]), 32'(id));
    check({p, "_latency"}, 32'(rsp_cyc[0] - acc_cyc[0]), 32'(1 + 33 * d_exp));
    check({p, "_rsp_id"}, 32'(rsp_id_q[0]), 32'(id));
    check({p, "_mosi"}, 32'(mosi_sr), 32'(mosi_exp));
    check({p, "_status"}, 32'(rsp_st_q[0]), 32'(st_exp));
    check({p, "_rdata"}, 32'(rsp_rd_q[0]), 32'(rd_exp));
    check({p, "_sclk_pulses"}, 32'(pulses), 32'd16);
    check({p, "_sclk_hi_min"}, 32'(hi_min), 32'(d_exp));
    check({p, "_sclk_hi_max"}, 32'(hi_max), 32'(d_exp));
    check({p, "_sclk_lo_min"}, 32'(lo_min), 32'(d_exp));
    check({p, "_sclk_lo_max"}, 32'(lo_max), 32'(d_exp));
    check({p, "_sclk_while_deselected"}, 32'(sclk_viol), 32'd0);
  endtask

  initial begin
    // Reset state, with a request pending that must not be acknowledged during reset
    r0_valid = 1'b1; r0_reg = 5'd1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready0", 32'(m_ready0), 32'd0);
    check("rst_ss_n", 32'(m_ss_n), 32'd1);
    check("rst_sclk", 32'(m_sclk), 32'd0);
    check("rst_mosi", 32'(m_mosi), 32'd0);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_rsp_valid", 32'(m_rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(m_rsp_id), 32'd0);
    check("rst_rdata", 32'(m_rdata), 32'd0);
    check("rst_status", 32'(m_status), 32'd0);
    r0_valid = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Write reg 17 = A5 from requester 0
    single(1'b0, 1'b1, 5'd17, 8'hA5, 16'h5AC3);
    check_txn("wr", 0, 16'h8AA5, 8'h5A, 8'hC3);

    // Read reg 19 from requester 1
    single(1'b1, 1'b0, 5'd19, 8'hFF, 16'h013C);
    check_txn("rd", 1, 16'h9800, 8'h01, 8'h3C);

    // Contention: both held valid for four grants
    @(posedge clk); #1;
    clear_mon(); miso_word = 16'h0000;
    r0_valid = 1'b1; r0_write = 1'b0; r0_reg = 5'd1;
    r1_valid = 1'b1; r1_write = 1'b0; r1_reg = 5'd2;
    wait_acc(4, 400);
    @(posedge clk); #1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    wait_rsp(4, 300);
    wait_idle();
    check("rr_id0", 32'(acc_id[0]), 32'd0);
    check("rr_id1", 32'(acc_id[1]), 32'd1);
    check("rr_id2", 32'(acc_id[2]), 32'd0);
    check("rr_id3", 32'(acc_id[3]), 32'd1);
    check("rr_space1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd69);
    check("rr_space2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd69);
    check("rr_space3", 32'(acc_cyc[3] - acc_cyc[2]), 32'd69);
    check("rr_ss_gap_min", 32'(gap_min), 32'd3);
    check("rr_ss_gap_max", 32'(gap_max), 32'd3);
    check("rr_rsp_order", 32'(rsp_id_q[1]), 32'd1);
    check("rr_sclk_while_deselected", 32'(sclk_viol), 32'd0);

    // Back-to-back: requester 0 held for three transactions
    @(posedge clk); #1;
    clear_mon();
    r0_valid = 1'b1; r0_write = 1'b1; r0_reg = 5'd4; r0_wdata = 8'h66;
    wait_acc(3, 300);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    wait_rsp(3, 300);
    wait_idle();
    check("b2b_id0", 32'(acc_id[0]), 32'd0);
    check("b2b_id1", 32'(acc_id[1]), 32'd0);
    check("b2b_id2", 32'(acc_id[2]), 32'd0);
    check("b2b_at69", 32'(acc_cyc[1] - acc_cyc[0]), 32'd69);
    check("b2b_at138", 32'(acc_cyc[2] - acc_cyc[0]), 32'd138);

    // Reset during bit 7 of the shift
    @(posedge clk); #1;
    clear_mon(); miso_word = 16'hFFFF;
    r0_valid = 1'b1; r0_write = 1'b1; r0_reg = 5'd9; r0_wdata = 8'h11;
    wait_acc(1, 50);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    for (int i = 0; i < 200 && pulses < 8; i++) begin @(negedge clk); #1; end
    check("abort_reached_bit7", 32'(pulses), 32'd8);
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    check("abort_ss_n", 32'(m_ss_n), 32'd1);
    check("abort_sclk", 32'(m_sclk), 32'd0);
    check("abort_mosi", 32'(m_mosi), 32'd0);
    check("abort_busy", 32'(m_busy), 32'd0);
    check("abort_rsp_valid", 32'(m_rsp_valid), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (80) @(negedge clk);
    #1;
    check("abort_no_rsp", 32'(rsp_cyc.size()), 32'd0);
    single(1'b0, 1'b0, 5'd5, 8'h00, 16'hA55A);
    check_txn("post_rst", 0, 16'h2800, 8'hA5, 8'h5A);

    // CLK_DIV = 1 instance: single read from requester 1
    @(posedge clk); #1;
    sel = 1'b1; d_exp = 1;
    repeat (2) @(posedge clk);
    single(1'b1, 1'b0, 5'd3, 8'h00, 16'h7E81);
    check_txn("div1", 1, 16'h1800, 8'h7E, 8'h81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
